// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // An index into a single-entry vector still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request after last_grant, with wrap.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]             req,
  input  logic [idx_width(NUM_REQ)-1:0]  last_grant,
  output logic                           found,
  output logic [idx_width(NUM_REQ)-1:0]  index
);

  localparam int IDX_W = idx_width(NUM_REQ);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    found    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
    // Offset NUM_REQ lands back on last_grant, so it is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
module fifo_rr_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  output logic [idx_width(NUM_REQ)-1:0]   grant_id,
  output logic                            grant_active
);

  localparam int               IDX_W     = idx_width(NUM_REQ);
  localparam int               CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  arb_state_t            state;
  logic [IDX_W-1:0]      last_grant;
  logic [CNT_W-1:0]      beat_cnt;
  logic [DATA_WIDTH-1:0] data_hold;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  holder_valid;
  logic [DATA_WIDTH-1:0] holder_data;
  logic                  handshake;
  logic                  release_grant;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .index      (pick_idx)
  );

  assign grant_active  = (state == GRANT);
  assign holder_valid  = req_valid[grant_id];
  assign holder_data   = words[grant_id];
  assign handshake     = grant_active & holder_valid & ~fifo_full;
  assign release_grant = (handshake && (beat_cnt == LAST_BEAT)) || !holder_valid;

  // The write port is driven straight from the holder so a word is accepted the cycle it is seen.
  assign fifo_wr_en   = handshake;
  assign fifo_data_in = handshake ? holder_data : data_hold;

  always_comb begin
    req_ready = '0;
    if (handshake) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= LAST_INIT;
      beat_cnt   <= '0;
      data_hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (handshake) begin
            beat_cnt  <= beat_cnt + 1'b1;
            data_hold <= holder_data;
          end
          // A full FIFO freezes the count but a vanished holder still gives up the grant.
          if (release_grant) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Directed scoreboard bench for the round-robin FIFO write arbiter.
module tb_fifo_rr_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_data_in;
  logic [1:0]        grant_id;
  logic              grant_active;

  always #5 clk = ~clk;

  fifo_rr_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .grant_active (grant_active)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] mem [NR][16];
  int         head [NR] = '{default: 0};
  int         tail [NR];
  logic       en   [NR];
  int         total = 0;
  int         bad   = 0;
  int         wr_cnt = 0;
  logic [NR-1:0] acc;

  // Producer models: a word is visible while enabled and not yet accepted.
  for (genvar gi = 0; gi < NR; gi++) begin : g_prod
    assign req_valid[gi]          = en[gi] && (head[gi] != tail[gi]);
    assign req_data[gi*DW +: DW]  = mem[gi][head[gi][3:0]];
  end

  always begin
    @(posedge clk);
    acc = req_ready;
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) head[i] = head[i] + 1;
    end
  end

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every FIFO write is matched against the next expected beat.
  always @(negedge clk) begin
    beat_t      e;
    logic [3:0] rdy;
    if (fifo_wr_en) begin
      wr_cnt++;
      chk_eq("no_write_while_full", 32'(fifo_full), 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %0h from %0d expected none", fifo_data_in, grant_id);
      end else begin
        e   = exp_q.pop_front();
        rdy = 4'b0001 << e.id;
        chk_eq("wr_data", 32'(fifo_data_in), 32'(e.data));
        chk_eq("wr_id", 32'(grant_id), 32'(e.id));
        chk_eq("ready_onehot", 32'(req_ready), 32'(rdy));
      end
    end
  end

  task automatic load(input int id, input logic [7:0] d);
    mem[id][tail[id][3:0]] = d;
    tail[id] = tail[id] + 1;
  endtask

  task automatic expect_w(input int id, input logic [7:0] d);
    exp_q.push_back(beat_t'{id: 2'(id), data: d});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    chk_eq(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_n;
    int wr0;
    rst       = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      en[i]   = 1'b0;
      tail[i] = 0;
      for (int j = 0; j < 16; j++) mem[i][j] = '0;
    end
    tick();
    neg();
    chk_eq("rst_grant_active", 32'(grant_active), 32'd0);
    chk_eq("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk_eq("rst_ready", 32'(req_ready), 32'd0);
    chk_eq("rst_grant_id", 32'(grant_id), 32'd0);
    chk_eq("rst_data", 32'(fifo_data_in), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single producer 2, six words: burst of four, bubble, re-grant for the rest.
    for (int k = 0; k < 6; k++) begin
      load(2, 8'hA0 + 8'(k));
      expect_w(2, 8'hA0 + 8'(k));
    end
    en[2] = 1'b1;
    neg();
    chk_eq("t1_idle_first", 32'(grant_active), 32'd0);
    chk_eq("t1_no_write_idle", 32'(fifo_wr_en), 32'd0);
    neg();
    chk_eq("t1_granted", 32'(grant_active), 32'd1);
    chk_eq("t1_grant_id", 32'(grant_id), 32'd2);
    neg();
    neg();
    neg();
    neg();
    chk_eq("t1_bubble", 32'(grant_active), 32'd0);
    neg();
    chk_eq("t1_regrant", 32'(grant_active), 32'd1);
    chk_eq("t1_regrant_id", 32'(grant_id), 32'd2);
    drain("t1_drain", 40);
    en[2] = 1'b0;
    tick();

    // All four producers valid: order 0,1,2,3,0 with four beats each.
    do_reset();
    for (int k = 0; k < 8; k++) load(0, 8'h00 + 8'(k));
    for (int i = 1; i < NR; i++) begin
      for (int k = 0; k < 4; k++) load(i, 8'(i * 16 + k));
    end
    for (int k = 0; k < 4; k++) expect_w(0, 8'h00 + 8'(k));
    for (int i = 1; i < NR; i++) begin
      for (int k = 0; k < 4; k++) expect_w(i, 8'(i * 16 + k));
    end
    for (int k = 4; k < 8; k++) expect_w(0, 8'h00 + 8'(k));
    wr0 = wr_cnt;
    idle_n = 0;
    for (int i = 0; i < NR; i++) en[i] = 1'b1;
    for (int c = 0; c < 25; c++) begin
      neg();
      if (!grant_active) idle_n++;
    end
    tick();
    chk_eq("t2_idle_cycles", 32'(idle_n), 32'd5);
    chk_eq("t2_write_count", 32'(wr_cnt - wr0), 32'd20);
    drain("t2_drain", 40);
    for (int i = 0; i < NR; i++) en[i] = 1'b0;
    tick();

    // Producer 1 stalled by a full FIFO for three cycles after its second beat.
    for (int k = 0; k < 4; k++) begin
      load(1, 8'hB0 + 8'(k));
      expect_w(1, 8'hB0 + 8'(k));
    end
    en[1] = 1'b1;
    neg();
    neg();
    neg();
    tick();
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      neg();
      chk_eq("t3_full_wr_en", 32'(fifo_wr_en), 32'd0);
      chk_eq("t3_full_ready", 32'(req_ready), 32'd0);
      chk_eq("t3_full_hold", 32'(grant_active), 32'd1);
      chk_eq("t3_full_id", 32'(grant_id), 32'd1);
    end
    tick();
    fifo_full = 1'b0;
    drain("t3_drain", 40);
    en[1] = 1'b0;
    tick();

    // Producer 0 drops valid after one beat; producer 3 is next, skipping 1 and 2.
    do_reset();
    load(0, 8'hC0);
    load(0, 8'hC1);
    load(3, 8'hD0);
    load(3, 8'hD1);
    expect_w(0, 8'hC0);
    expect_w(3, 8'hD0);
    expect_w(3, 8'hD1);
    en[0] = 1'b1;
    en[3] = 1'b1;
    neg();
    neg();
    chk_eq("t4_first_grant", 32'(grant_id), 32'd0);
    tick();
    en[0] = 1'b0;
    neg();
    chk_eq("t4_dropped_no_write", 32'(fifo_wr_en), 32'd0);
    neg();
    chk_eq("t4_released", 32'(grant_active), 32'd0);
    neg();
    chk_eq("t4_next_active", 32'(grant_active), 32'd1);
    chk_eq("t4_next_id", 32'(grant_id), 32'd3);
    drain("t4_drain", 40);
    tail[0] = head[0];
    en[3] = 1'b0;
    tick();

    // Reset in the middle of a burst from producer 2.
    for (int k = 0; k < 4; k++) load(2, 8'hE0 + 8'(k));
    expect_w(2, 8'hE0);
    expect_w(2, 8'hE1);
    en[2] = 1'b1;
    neg();
    neg();
    neg();
    tick();
    rst = 1'b1;
    load(0, 8'hF0);
    load(0, 8'hF1);
    expect_w(0, 8'hF0);
    expect_w(0, 8'hF1);
    expect_w(2, 8'hE2);
    expect_w(2, 8'hE3);
    en[0] = 1'b1;
    #1;
    chk_eq("t5_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk_eq("t5_rst_ready", 32'(req_ready), 32'd0);
    chk_eq("t5_rst_active", 32'(grant_active), 32'd0);
    chk_eq("t5_rst_data", 32'(fifo_data_in), 32'd0);
    chk_eq("t5_rst_exp_left", 32'(exp_q.size()), 32'd4);
    tick();
    rst = 1'b0;
    neg();
    chk_eq("t5_post_rst_idle", 32'(grant_active), 32'd0);
    neg();
    chk_eq("t5_p0_first_active", 32'(grant_active), 32'd1);
    chk_eq("t5_p0_first_id", 32'(grant_id), 32'd0);
    drain("t5_drain", 40);
    en[0] = 1'b0;
    en[2] = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
